alu_issue_queue: RTL



---
 rtl/alu_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/alu_issue_queue.sv | 80 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU instruction-format definitions: field positions, widths and a packing helper.
package alu_pkg;

  localparam int INSTR_W  = 22;
  localparam int REG_W    = 5;
  localparam int OPC_W    = 7;

  localparam int OPC_MSB  = 21;
  localparam int OPC_LSB  = 15;
  localparam int DST_MSB  = 14;
  localparam int DST_LSB  = 10;
  localparam int SRC1_MSB = 9;
  localparam int SRC1_LSB = 5;
  localparam int SRC2_MSB = 4;
  localparam int SRC2_LSB = 0;

  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic [OPC_W-1:0] opc,
    input logic [REG_W-1:0] dst,
    input logic [REG_W-1:0] s1,
    input logic [REG_W-1:0] s2
  );
    return {opc, dst, s1, s2};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead read, flush, and level-derived full/empty.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en, rd_en;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  // Flush wins over both sides; a full queue never accepts, even alongside a pop.
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the pipelined ALU: buffers instructions, presents the head
// decoded into fields, holds it under stall, and counts issues and stalled cycles.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = alu_pkg::INSTR_W,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  input  logic                     stall,
  output logic [REG_W-1:0]         src1,
  output logic [REG_W-1:0]         src2,
  output logic [REG_W-1:0]         dest_addr,
  output logic [OPC_W-1:0]         opcode,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [INSTR_W-1:0] head_raw;
  logic [INSTR_W-1:0] head;
  logic               full, empty, pop;
  logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .flush (flush),
    .wdata (in_instr),
    .rdata (head_raw),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign valid    = !empty;
  assign in_ready = !full;
  // The ALU stage-1 register samples the head in exactly this cycle.
  assign pop      = valid && !stall;

  assign head      = empty ? '0 : head_raw;
  assign opcode    = head[OPC_MSB:OPC_LSB];
  assign dest_addr = head[DST_MSB:DST_LSB];
  assign src1      = head[SRC1_MSB:SRC1_LSB];
  assign src2      = head[SRC2_MSB:SRC2_LSB];

  always_comb begin
    issued_cnt_d = issued_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (pop && !flush) issued_cnt_d = issued_cnt_q + CNT_W'(1);
    if (valid && stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign issued_cnt = issued_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
